// File: rtl/eeg_aram_pkg.sv
// Shared ARAM router constants, sequencer state encoding and burst descriptor.
package eeg_aram_pkg;

  localparam int unsigned ARAM_ADD_AW = 12;
  localparam int unsigned ARAM_DAT_DW = 4;
  localparam int unsigned ARAM_NUM_AW = 2;
  localparam int unsigned LEN_AW      = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [ARAM_ADD_AW-1:0] base;
    logic [LEN_AW-1:0]      len;
    logic [ARAM_ADD_AW-1:0] stride;
    logic [ARAM_NUM_AW-1:0] rid;
  } desc_t;

endpackage

// File: rtl/eeg_crd_cnt.sv
// Saturating up/down counter of outstanding reads with a full flag.
module eeg_crd_cnt #(
  parameter int unsigned CRD_NUM = 4,
  parameter int unsigned CRD_AW  = $clog2(CRD_NUM) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_inc,
  input  logic i_dec,
  output logic o_full
);

  logic [CRD_AW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_inc && !i_dec && (r_cnt != CRD_AW'(CRD_NUM))) begin
      r_cnt <= r_cnt + CRD_AW'(1);
    end else if (i_dec && !i_inc && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CRD_AW'(1);
    end
  end

  assign o_full = (r_cnt == CRD_AW'(CRD_NUM));

endmodule

// File: rtl/eeg_aram_rd_ctrl.sv
// Read-burst sequencer for one ARAM router requester slot: issues a strided
// address stream under a credit limit and forwards returned data with its own last marker.
module eeg_aram_rd_ctrl
  import eeg_aram_pkg::*;
#(
  parameter int unsigned CRD_NUM = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   CFG_VLD,
  output logic                   CFG_RDY,
  input  logic [ARAM_ADD_AW-1:0] CFG_BASE,
  input  logic [LEN_AW-1:0]      CFG_LEN,
  input  logic [ARAM_ADD_AW-1:0] CFG_STRIDE,
  input  logic [ARAM_NUM_AW-1:0] CFG_RID,
  output logic [ARAM_NUM_AW-1:0] ARAM_ADD_RID,
  output logic                   ARAM_ADD_VLD,
  output logic                   ARAM_ADD_LST,
  input  logic                   ARAM_ADD_RDY,
  output logic [ARAM_ADD_AW-1:0] ARAM_ADD_ADD,
  input  logic                   ARAM_DAT_VLD,
  input  logic                   ARAM_DAT_LST,
  output logic                   ARAM_DAT_RDY,
  input  logic [ARAM_DAT_DW-1:0] ARAM_DAT_DAT,
  output logic                   OUT_DAT_VLD,
  output logic                   OUT_DAT_LST,
  input  logic                   OUT_DAT_RDY,
  output logic [ARAM_DAT_DW-1:0] OUT_DAT_DAT,
  output logic                   BUSY,
  output logic                   DONE,
  output logic                   ERR
);

  localparam int unsigned CRD_AW = $clog2(CRD_NUM) + 1;

  state_t                 r_state;
  state_t                 w_state_nxt;
  desc_t                  w_cfg;
  logic [ARAM_ADD_AW-1:0] r_add_cnt;
  logic [ARAM_ADD_AW-1:0] r_stride;
  logic [LEN_AW-1:0]      r_rem_add;
  logic [LEN_AW-1:0]      r_rem_dat;
  logic [ARAM_NUM_AW-1:0] r_rid;
  logic                   r_done;
  logic                   r_err;
  logic                   w_cfg_hs;
  logic                   w_add_hs;
  logic                   w_dat_hs;
  logic                   w_add_fin;
  logic                   w_dat_lst;
  logic                   w_dat_fin;
  logic                   w_crd_full;

  assign w_cfg = '{base: CFG_BASE, len: CFG_LEN, stride: CFG_STRIDE, rid: CFG_RID};

  assign CFG_RDY  = (r_state == IDLE);
  assign w_cfg_hs = CFG_VLD && CFG_RDY;
  assign BUSY     = (r_state != IDLE);

  assign ARAM_ADD_VLD = (r_state == ISSUE) && !w_crd_full;
  assign ARAM_ADD_LST = ARAM_ADD_VLD && (r_rem_add == '0);
  assign ARAM_ADD_ADD = r_add_cnt;
  assign ARAM_ADD_RID = r_rid;
  assign w_add_hs     = ARAM_ADD_VLD && ARAM_ADD_RDY;
  assign w_add_fin    = w_add_hs && (r_rem_add == '0);

  // Zero-latency data pass-through, blocked while idle.
  assign OUT_DAT_VLD  = ARAM_DAT_VLD && BUSY;
  assign ARAM_DAT_RDY = OUT_DAT_RDY && BUSY;
  assign OUT_DAT_DAT  = ARAM_DAT_DAT;
  assign w_dat_lst    = (r_rem_dat == '0);
  assign OUT_DAT_LST  = OUT_DAT_VLD && w_dat_lst;
  assign w_dat_hs     = ARAM_DAT_VLD && ARAM_DAT_RDY;
  assign w_dat_fin    = w_dat_hs && w_dat_lst;

  assign DONE = r_done;
  assign ERR  = r_err;

  eeg_crd_cnt #(
    .CRD_NUM (CRD_NUM),
    .CRD_AW  (CRD_AW)
  ) u_crd_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_inc  (w_add_hs),
    .i_dec  (w_dat_hs),
    .o_full (w_crd_full)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_cfg_hs)  w_state_nxt = ISSUE;
      ISSUE:   if (w_add_fin) w_state_nxt = DRAIN;
      DRAIN:   if (w_dat_fin) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Descriptor latch plus address/beat bookkeeping; cfg and data handshakes never coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_add_cnt <= '0;
      r_stride  <= '0;
      r_rem_add <= '0;
      r_rem_dat <= '0;
      r_rid     <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      if (w_cfg_hs) begin
        r_add_cnt <= w_cfg.base;
        r_stride  <= w_cfg.stride;
        r_rem_add <= w_cfg.len;
        r_rem_dat <= w_cfg.len;
        r_rid     <= w_cfg.rid;
      end else begin
        if (w_add_hs) begin
          r_add_cnt <= r_add_cnt + r_stride;
          if (r_rem_add != '0) r_rem_add <= r_rem_add - LEN_AW'(1);
        end
        if (w_dat_hs && !w_dat_lst) r_rem_dat <= r_rem_dat - LEN_AW'(1);
      end
      r_done <= w_dat_fin;
      if (w_dat_hs && (ARAM_DAT_LST != w_dat_lst)) r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_eeg_aram_rd_ctrl.sv
// Scoreboard bench for eeg_aram_rd_ctrl with a behavioural router model.
module tb_eeg_aram_rd_ctrl;
  import eeg_aram_pkg::*;

  localparam int CRD = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   CFG_VLD, CFG_RDY;
  logic [ARAM_ADD_AW-1:0] CFG_BASE, CFG_STRIDE;
  logic [LEN_AW-1:0]      CFG_LEN;
  logic [ARAM_NUM_AW-1:0] CFG_RID, ARAM_ADD_RID;
  logic                   ARAM_ADD_VLD, ARAM_ADD_LST, ARAM_ADD_RDY;
  logic [ARAM_ADD_AW-1:0] ARAM_ADD_ADD;
  logic                   ARAM_DAT_VLD, ARAM_DAT_LST, ARAM_DAT_RDY;
  logic [ARAM_DAT_DW-1:0] ARAM_DAT_DAT, OUT_DAT_DAT;
  logic                   OUT_DAT_VLD, OUT_DAT_LST, OUT_DAT_RDY;
  logic                   BUSY, DONE, ERR;

  typedef struct packed {
    logic [ARAM_DAT_DW-1:0] dat;
    logic                   lst;
  } beat_t;

  int                     n_chk = 0;
  int                     n_fail = 0;
  bit                     m_err = 1'b0;
  int                     g_nbeats;
  logic [ARAM_ADD_AW-1:0] exp_add_q[$];
  logic [ARAM_ADD_AW-1:0] obs_add_q[$];
  beat_t                  exp_out_q[$];
  beat_t                  pend_q[$];

  always #5 clk = ~clk;

  eeg_aram_rd_ctrl #(.CRD_NUM(CRD)) dut (
    .clk(clk), .rst(rst),
    .CFG_VLD(CFG_VLD), .CFG_RDY(CFG_RDY), .CFG_BASE(CFG_BASE), .CFG_LEN(CFG_LEN),
    .CFG_STRIDE(CFG_STRIDE), .CFG_RID(CFG_RID),
    .ARAM_ADD_RID(ARAM_ADD_RID), .ARAM_ADD_VLD(ARAM_ADD_VLD), .ARAM_ADD_LST(ARAM_ADD_LST),
    .ARAM_ADD_RDY(ARAM_ADD_RDY), .ARAM_ADD_ADD(ARAM_ADD_ADD),
    .ARAM_DAT_VLD(ARAM_DAT_VLD), .ARAM_DAT_LST(ARAM_DAT_LST), .ARAM_DAT_RDY(ARAM_DAT_RDY),
    .ARAM_DAT_DAT(ARAM_DAT_DAT),
    .OUT_DAT_VLD(OUT_DAT_VLD), .OUT_DAT_LST(OUT_DAT_LST), .OUT_DAT_RDY(OUT_DAT_RDY),
    .OUT_DAT_DAT(OUT_DAT_DAT),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  function automatic logic [ARAM_DAT_DW-1:0] dat_of(input logic [ARAM_ADD_AW-1:0] a);
    return a[3:0] ^ a[7:4] ^ a[11:8];
  endfunction

  task automatic drive_idle();
    CFG_VLD = 1'b0; CFG_BASE = '0; CFG_LEN = '0; CFG_STRIDE = '0; CFG_RID = '0;
    ARAM_ADD_RDY = 1'b0; ARAM_DAT_VLD = 1'b0; ARAM_DAT_LST = 1'b0; ARAM_DAT_DAT = '0;
    OUT_DAT_RDY = 1'b0;
  endtask

  // One burst against the router model. hold: cycles before any read data returns;
  // tog: consumer ready alternates; err_beat>=0: router flags last on that beat;
  // abort_after>0: leave after that many address handshakes.
  task automatic run_burst(input logic [ARAM_ADD_AW-1:0] base, input logic [LEN_AW-1:0] len,
                           input logic [ARAM_ADD_AW-1:0] stride, input logic [ARAM_NUM_AW-1:0] rid,
                           input int hold, input bit tog, input int err_beat, input int abort_after);
    int cyc, n_add, n_dat, outst, ilen;
    bit busy, done_exp, fin, exp_avld, exp_ovld, add_hs, out_hs;
    logic [ARAM_ADD_AW-1:0] a, ea;
    beat_t b, eb;
    ilen = int'(len);
    a = base;
    for (int i = 0; i <= ilen; i++) begin
      exp_add_q.push_back(a);
      eb.dat = dat_of(a);
      eb.lst = (i == ilen);
      exp_out_q.push_back(eb);
      a = a + stride;
    end
    obs_add_q.delete();
    pend_q.delete();
    cyc = 0; n_add = 0; n_dat = 0; outst = 0;
    busy = 1'b0; done_exp = 1'b0; fin = 1'b0;
    while (!fin) begin
      @(negedge clk);
      CFG_VLD = (cyc == 0); CFG_BASE = base; CFG_LEN = len; CFG_STRIDE = stride; CFG_RID = rid;
      ARAM_ADD_RDY = 1'b1;
      OUT_DAT_RDY  = tog ? (cyc % 2 == 0) : 1'b1;
      ARAM_DAT_VLD = (pend_q.size() > 0) && (cyc >= hold);
      if (pend_q.size() > 0) {ARAM_DAT_DAT, ARAM_DAT_LST} = pend_q[0];
      else {ARAM_DAT_DAT, ARAM_DAT_LST} = '0;
      #1;
      exp_avld = busy && (n_add <= ilen) && (outst < CRD);
      exp_ovld = ARAM_DAT_VLD && busy;
      n_chk++; if (CFG_RDY !== !busy) begin n_fail++; $display("FAIL cfg_rdy cyc=%0d got %b want %b", cyc, CFG_RDY, !busy); end
      n_chk++; if (BUSY !== busy) begin n_fail++; $display("FAIL busy cyc=%0d got %b want %b", cyc, BUSY, busy); end
      n_chk++; if (DONE !== done_exp) begin n_fail++; $display("FAIL done cyc=%0d got %b want %b", cyc, DONE, done_exp); end
      n_chk++; if (ERR !== m_err) begin n_fail++; $display("FAIL err cyc=%0d got %b want %b", cyc, ERR, m_err); end
      n_chk++; if (ARAM_ADD_VLD !== exp_avld) begin n_fail++; $display("FAIL add_vld cyc=%0d got %b want %b (issued %0d outst %0d)", cyc, ARAM_ADD_VLD, exp_avld, n_add, outst); end
      n_chk++; if (ARAM_ADD_LST !== (exp_avld && n_add == ilen)) begin n_fail++; $display("FAIL add_lst cyc=%0d got %b", cyc, ARAM_ADD_LST); end
      n_chk++; if (OUT_DAT_VLD !== exp_ovld) begin n_fail++; $display("FAIL out_vld cyc=%0d got %b want %b", cyc, OUT_DAT_VLD, exp_ovld); end
      n_chk++; if (OUT_DAT_LST !== (exp_ovld && n_dat == ilen)) begin n_fail++; $display("FAIL out_lst cyc=%0d got %b", cyc, OUT_DAT_LST); end
      n_chk++; if (ARAM_DAT_RDY !== (OUT_DAT_RDY && busy)) begin n_fail++; $display("FAIL dat_rdy cyc=%0d got %b want %b", cyc, ARAM_DAT_RDY, OUT_DAT_RDY && busy); end
      if (hold > 0 && cyc == hold - 1) begin
        n_chk++; if (n_add != ((ilen + 1 < CRD) ? ilen + 1 : CRD)) begin n_fail++; $display("FAIL credit_stall got %0d addresses want %0d", n_add, CRD); end
      end
      add_hs = ARAM_ADD_VLD && ARAM_ADD_RDY;
      out_hs = OUT_DAT_VLD && OUT_DAT_RDY;
      if (add_hs) begin
        obs_add_q.push_back(ARAM_ADD_ADD);
        n_chk++;
        if (exp_add_q.size() == 0) begin n_fail++; $display("FAIL extra_addr got %0h", ARAM_ADD_ADD); end
        else begin
          ea = exp_add_q.pop_front();
          if (ARAM_ADD_ADD !== ea || ARAM_ADD_RID !== rid) begin
            n_fail++; $display("FAIL addr got %0h/rid %0d want %0h/rid %0d", ARAM_ADD_ADD, ARAM_ADD_RID, ea, rid);
          end
        end
      end
      if (out_hs) begin
        n_chk++;
        if (exp_out_q.size() == 0) begin n_fail++; $display("FAIL extra_beat got %0h", OUT_DAT_DAT); end
        else begin
          eb = exp_out_q.pop_front();
          if (OUT_DAT_DAT !== eb.dat || OUT_DAT_LST !== eb.lst) begin
            n_fail++; $display("FAIL beat got %0h/%b want %0h/%b", OUT_DAT_DAT, OUT_DAT_LST, eb.dat, eb.lst);
          end
        end
      end
      fin = done_exp;
      done_exp = 1'b0;
      if (out_hs) begin
        b = pend_q.pop_front();
        if (b.lst != (n_dat == ilen)) m_err = 1'b1;
        n_dat++; outst--;
        if (n_dat > ilen) begin busy = 1'b0; done_exp = 1'b1; end
      end
      if (add_hs) begin
        b.dat = dat_of(ARAM_ADD_ADD);
        b.lst = (err_beat >= 0) ? (n_add == err_beat) : (n_add == ilen);
        pend_q.push_back(b);
        n_add++; outst++;
      end
      if (cyc == 0 && CFG_RDY) busy = 1'b1;
      if (abort_after > 0 && n_add == abort_after) fin = 1'b1;
      cyc++;
      if (cyc > 500) begin n_fail++; $display("FAIL timeout burst base=%0h after %0d cycles", base, cyc); fin = 1'b1; end
    end
    g_nbeats = n_dat;
    CFG_VLD = 1'b0;
    if (abort_after == 0) begin
      n_chk++;
      if (exp_add_q.size() != 0 || exp_out_q.size() != 0) begin
        n_fail++; $display("FAIL leftover got %0d addr %0d beats want 0 0", exp_add_q.size(), exp_out_q.size());
      end
    end
  endtask

  task automatic test_reset();
    logic [25:0] got;
    drive_idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    got = {ARAM_ADD_RID, ARAM_ADD_VLD, ARAM_ADD_LST, ARAM_ADD_ADD, ARAM_DAT_RDY, OUT_DAT_VLD,
           OUT_DAT_LST, OUT_DAT_DAT, BUSY, DONE, ERR};
    n_chk++; if (got !== 26'd0) begin n_fail++; $display("FAIL reset_outputs got %0h want 0", got); end
    n_chk++; if (CFG_RDY !== 1'b1) begin n_fail++; $display("FAIL reset_cfg_rdy got %b want 1", CFG_RDY); end
  endtask

  task automatic test_basic();
    logic [ARAM_ADD_AW-1:0] want[4];
    want = '{12'h010, 12'h012, 12'h014, 12'h016};
    run_burst(12'h010, 12'd3, 12'd2, 2'd1, 0, 1'b0, -1, 0);
    n_chk++; if (obs_add_q.size() != 4) begin n_fail++; $display("FAIL basic_count got %0d want 4", obs_add_q.size()); end
    for (int i = 0; i < 4 && i < obs_add_q.size(); i++) begin
      n_chk++; if (obs_add_q[i] !== want[i]) begin n_fail++; $display("FAIL basic_addr%0d got %0h want %0h", i, obs_add_q[i], want[i]); end
    end
    n_chk++; if (ERR !== 1'b0) begin n_fail++; $display("FAIL basic_err got %b want 0", ERR); end
  endtask

  task automatic test_credit();
    run_burst(12'h200, 12'd7, 12'd1, 2'd0, 10, 1'b0, -1, 0);
    n_chk++; if (obs_add_q.size() != 8) begin n_fail++; $display("FAIL credit_count got %0d want 8", obs_add_q.size()); end
  endtask

  task automatic test_wrap();
    logic [ARAM_ADD_AW-1:0] want[4];
    want = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
    run_burst(12'hFFE, 12'd3, 12'd1, 2'd3, 0, 1'b0, -1, 0);
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (i >= obs_add_q.size()) begin n_fail++; $display("FAIL wrap_addr%0d got none want %0h", i, want[i]); end
      else if (obs_add_q[i] !== want[i]) begin n_fail++; $display("FAIL wrap_addr%0d got %0h want %0h", i, obs_add_q[i], want[i]); end
    end
  endtask

  task automatic test_rdy_toggle();
    run_burst(12'h040, 12'd5, 12'd3, 2'd2, 0, 1'b1, -1, 0);
    n_chk++; if (g_nbeats != 6) begin n_fail++; $display("FAIL toggle_beats got %0d want 6", g_nbeats); end
  endtask

  task automatic test_err();
    run_burst(12'h080, 12'd3, 12'd1, 2'd0, 0, 1'b0, 1, 0);
    n_chk++; if (ERR !== 1'b1) begin n_fail++; $display("FAIL err_set got %b want 1", ERR); end
    run_burst(12'h0A0, 12'd1, 12'd1, 2'd1, 0, 1'b0, -1, 0);
    n_chk++; if (ERR !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %b want 1", ERR); end
  endtask

  task automatic test_reset_mid();
    logic [25:0] got;
    run_burst(12'h100, 12'd7, 12'd4, 2'd2, 0, 1'b0, -1, 2);
    @(negedge clk);
    drive_idle();
    rst = 1'b1;
    exp_add_q.delete(); exp_out_q.delete(); pend_q.delete();
    m_err = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    got = {ARAM_ADD_RID, ARAM_ADD_VLD, ARAM_ADD_LST, ARAM_ADD_ADD, ARAM_DAT_RDY, OUT_DAT_VLD,
           OUT_DAT_LST, OUT_DAT_DAT, BUSY, DONE, ERR};
    n_chk++; if (got !== 26'd0) begin n_fail++; $display("FAIL midrst_outputs got %0h want 0", got); end
    n_chk++; if (CFG_RDY !== 1'b1) begin n_fail++; $display("FAIL midrst_cfg_rdy got %b want 1", CFG_RDY); end
    run_burst(12'h123, 12'd0, 12'd5, 2'd1, 0, 1'b0, -1, 0);
    n_chk++; if (obs_add_q.size() != 1) begin n_fail++; $display("FAIL len0_count got %0d want 1", obs_add_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_credit();
    test_wrap();
    test_rdy_toggle();
    test_err();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/eeg_aram_rd_ctrl.md
Name: eeg_aram_rd_ctrl

Overview:
- Read-burst sequencer for one requester port of the ARAM router.
- Accepts a burst descriptor (base, length, stride, target RAM id) and issues the address stream on the router's ADD channel, with a credit limit on outstanding reads.
- Forwards returned data to a downstream consumer, generates its own last-beat marker, and signals completion.
- One instance per router requester slot; sits between the layer controller and the ARAM router.

Parameters:
- ARAM_ADD_AW, 12, ARAM address width.
- ARAM_DAT_DW, 4, ARAM data width.
- ARAM_NUM_AW, 2, RAM-id width.
- LEN_AW, 12, burst length field width.
- CRD_NUM, 4, max outstanding reads (power of two, ≥1).
- CRD_AW, $clog2(CRD_NUM)+1, credit counter width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- CFG_VLD  in  1  descriptor valid
- CFG_RDY  out  1  descriptor accepted (IDLE only)
- CFG_BASE  in  ARAM_ADD_AW  first address
- CFG_LEN  in  LEN_AW  beats minus 1
- CFG_STRIDE  in  ARAM_ADD_AW  address increment per beat
- CFG_RID  in  ARAM_NUM_AW  target RAM id
- ARAM_ADD_RID  out  ARAM_NUM_AW  latched RAM id
- ARAM_ADD_VLD  out  1  address valid
- ARAM_ADD_LST  out  1  final address of burst
- ARAM_ADD_RDY  in  1  router accepts address
- ARAM_ADD_ADD  out  ARAM_ADD_AW  address
- ARAM_DAT_VLD  in  1  read data valid
- ARAM_DAT_LST  in  1  router last flag (checked only)
- ARAM_DAT_RDY  out  1  ready for read data
- ARAM_DAT_DAT  in  ARAM_DAT_DW  read data
- OUT_DAT_VLD  out  1  data to consumer
- OUT_DAT_LST  out  1  final beat of burst
- OUT_DAT_RDY  in  1  consumer ready
- OUT_DAT_DAT  out  ARAM_DAT_DW  data
- BUSY  out  1  state != IDLE
- DONE  out  1  one-cycle pulse after final data handshake
- ERR  out  1  sticky LST-mismatch flag

Behaviour:
- Handshake: a transfer occurs when VLD & RDY are both high on a rising edge. VLD never drops until the transfer completes; payload stays stable while VLD is high.
- FSM: IDLE -> ISSUE on CFG_VLD&CFG_RDY; ISSUE -> DRAIN on the final address handshake; DRAIN -> IDLE on the final data handshake.
- CFG_LEN=0 is a single beat; ISSUE and DRAIN may overlap in time.
- On config accept, latch:
  - add_cnt=CFG_BASE
  - rem_add=CFG_LEN, rem_dat=CFG_LEN
  - stride, rid
- ARAM_ADD_VLD = (state==ISSUE) && (crd < CRD_NUM).
- ARAM_ADD_ADD=add_cnt. On each address handshake, add_cnt += stride, modulo 2^ARAM_ADD_AW (wrap silently).
- ARAM_ADD_LST = ARAM_ADD_VLD && (rem_add==0).
- crd: +1 on address handshake, -1 on data handshake; both in the same cycle leaves it unchanged. crd never exceeds CRD_NUM or goes below 0.
- Data path is combinational pass-through, zero latency:
  - OUT_DAT_VLD = ARAM_DAT_VLD && state!=IDLE
  - ARAM_DAT_RDY = OUT_DAT_RDY && state!=IDLE
  - OUT_DAT_DAT = ARAM_DAT_DAT
- OUT_DAT_LST = OUT_DAT_VLD && (rem_dat==0). rem_dat decrements on each data handshake.
- ERR sets on a data handshake where ARAM_DAT_LST != internal last. It clears only on rst.
- DONE is registered: high the cycle after the final data handshake, the same cycle state==IDLE. CFG_RDY is high that cycle, so back-to-back bursts are allowed.
- Data arriving in IDLE is not accepted (RDY=0).
- Reset: all state cleared. FSM=IDLE, crd=0, every output 0 except CFG_RDY=1 (after reset release).
- Reset mid-burst abandons the burst. The router must be reset in the same cycle (system requirement).
- Latency: first address valid the cycle after config accept. Minimum burst duration (LEN+1) cycles when the router is always ready.

Decomposition:
- Shared package eeg_aram_pkg: ARAM_ADD_AW/ARAM_DAT_DW/ARAM_NUM_AW constants, FSM state enum (IDLE, ISSUE, DRAIN), descriptor struct {base, len, stride, rid}.
- Optional sub-module eeg_crd_cnt: saturating up/down credit counter with full flag. Everything else is inline.

Test Plan:
- BASE=0x010, LEN=3, STRIDE=2, RID=1, router always ready, data 1 cycle after address -> addresses 0x010,0x012,0x014,0x016; LST on 0x016; 4 OUT beats, LST on 4th; DONE 1 cycle after; ERR=0.
- LEN=7, ADD_RDY=1, data withheld -> exactly 4 addresses issued, then ADD_VLD=0 until the first data handshake frees a credit.
- BASE=0xFFE, STRIDE=1, LEN=3 -> addresses 0xFFE,0xFFF,0x000,0x001 (wrap).
- OUT_DAT_RDY toggled 1/0 every cycle, LEN=5 -> ARAM_DAT_RDY mirrors it, no beat lost or duplicated, 6 beats total.
- Router raises ARAM_DAT_LST on beat 2 of 4 -> ERR=1 from the next cycle, stays set through the next burst until rst.
- rst asserted mid-ISSUE after 2 addresses -> next cycle all outputs 0, CFG_RDY=1; a new burst LEN=0 completes with 1 address and DONE.
